// File: rtl/ci_pkg.sv
// ci_pkg
//  Shared constants for the CI radius pipeline: pixel width, full window
//  height, and the first tap each radius slice reads from the column window.
//  Also holds the zero-pad validity helper used by the row window buffer.
package ci_pkg;

  localparam int PIX_W    = 8;
  localparam int CI_TAPS  = 17;

  // Radius slices take taps [Rn_FIRST .. CI_TAPS-1] of the column window
  localparam int R2_FIRST = 12;
  localparam int R4_FIRST = 8;
  localparam int R6_FIRST = 4;
  localparam int R8_FIRST = 0;

  // Tap k of a window of height taps carries real data once the live row
  // has advanced far enough that row r-(taps-1-k) exists in this frame.
  function automatic logic tap_filled(input int row, input int k, input int taps);
    return row >= (taps - 1 - k);
  endfunction

endpackage

// File: rtl/ci_line_ram.sv
// ci_line_ram
//  One line of pixel history: DEPTH words of DATA_W bits.
//  Asynchronous read of the addressed word, synchronous write on clk, so at
//  a shared address the old word is observed in the same cycle it is
//  overwritten (read-before-write). Contents are never reset.
// Ports
//  clk    in   1        clock
//  we     in   1        write enable
//  addr   in   ADDR_W   read and write address
//  wdata  in   DATA_W   word written at addr on the rising edge
//  rdata  out  DATA_W   current (pre-write) word at addr
module ci_line_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 30,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Storage only; validity of the data is tracked by the owner's row counter
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/ci_row_window_buffer.sv
// ci_row_window_buffer
//  Turns a raster pixel stream into one vertical column of TAPS same-column
//  pixels per accepted input pixel, tagged with the live pixel's row/column.
//  TAPS-1 chained line RAMs hold the previous rows; the live pixel is the
//  newest tap. ZERO_PAD=0 emits only once the window is full, ZERO_PAD=1
//  emits every pixel with not-yet-filled taps forced to zero.
// Ports
//  clk           in   1             clock
//  rst           in   1             asynchronous active-high reset
//  done_i        in   1             data_i valid strobe
//  data_i        in   DATA_W        pixel, raster order
//  clear_i       in   1             synchronous frame abort
//  taps_o        out  TAPS*DATA_W   tap k at [k*DATA_W +: DATA_W], k=0 oldest row
//  row_o         out  clog2(ROWS)   row of the live pixel
//  col_o         out  clog2(COLS)   column of the window
//  done_o        out  1             outputs valid pulse
//  frame_done_o  out  1             pulse with the last pixel of a frame
module ci_row_window_buffer
  import ci_pkg::*;
#(
  parameter int DATA_W   = PIX_W,
  parameter int COLS     = 30,
  parameter int ROWS     = 30,
  parameter int TAPS     = CI_TAPS,
  parameter int ZERO_PAD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     clear_i,
  output logic [TAPS*DATA_W-1:0]   taps_o,
  output logic [$clog2(ROWS)-1:0]  row_o,
  output logic [$clog2(COLS)-1:0]  col_o,
  output logic                     done_o,
  output logic                     frame_done_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [CW-1:0]          col_cnt;
  logic [RW-1:0]          row_cnt;
  logic                   accept;
  logic                   last_col;
  logic                   last_row;
  logic                   emit;
  logic [DATA_W-1:0]      ram_out [TAPS-1];
  logic [DATA_W-1:0]      tap_raw [TAPS];
  logic [TAPS*DATA_W-1:0] tap_next;

  // A clear in the same cycle as a pixel drops the pixel, so the RAMs must
  // not see the write either.
  assign accept   = done_i & ~clear_i;
  assign last_col = (col_cnt == CW'(COLS - 1));
  assign last_row = (row_cnt == RW'(ROWS - 1));
  assign emit     = (ZERO_PAD != 0) || (int'(row_cnt) >= (TAPS - 1));

  // RAM j feeds RAM j-1: the word leaving RAM j+1 is one row older than what
  // RAM j+1 just received, which is exactly what RAM j must store.
  for (genvar j = 0; j < TAPS - 1; j++) begin : g_line
    ci_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (COLS),
      .ADDR_W (CW)
    ) u_line_ram (
      .clk   (clk),
      .we    (accept),
      .addr  (col_cnt),
      .wdata (tap_raw[j+1]),
      .rdata (ram_out[j])
    );
  end

  // Raw window: RAM outputs for the history, the live pixel on top
  always_comb begin
    for (int k = 0; k < TAPS - 1; k++) begin
      tap_raw[k] = ram_out[k];
    end
    tap_raw[TAPS-1] = data_i;
  end

  // In zero-pad mode the RAMs may still hold the previous frame, so taps
  // above the rows seen so far in this frame are masked to zero.
  always_comb begin
    tap_next = '0;
    for (int k = 0; k < TAPS; k++) begin
      if ((ZERO_PAD == 0) || tap_filled(int'(row_cnt), k, TAPS)) begin
        tap_next[k*DATA_W +: DATA_W] = tap_raw[k];
      end
    end
  end

  // Position counters and registered outputs. The final pixel of a frame
  // wraps both counters so the next frame can follow without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      taps_o       <= '0;
      row_o        <= '0;
      col_o        <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else if (clear_i) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      if (done_i) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
        if (emit) begin
          done_o       <= 1'b1;
          taps_o       <= tap_next;
          row_o        <= row_cnt;
          col_o        <= col_cnt;
          frame_done_o <= last_col & last_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_ci_row_window_buffer.sv
// tb_ci_row_window_buffer
//  Directed bench for the row window buffer with COLS=4, ROWS=6, TAPS=3.
//  Two instances share one stimulus stream: dut_np without zero padding and
//  dut_zp with zero padding. Pixel value is 16*row+col of its counted
//  position, so expected taps follow directly from the position.
module tb_ci_row_window_buffer;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int NR = 6;
  localparam int NT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           done_i = 1'b0;
  logic [DW-1:0]  data_i = '0;
  logic           clear_i = 1'b0;

  logic [NT*DW-1:0] np_taps, zp_taps;
  logic [2:0]       np_row, zp_row;
  logic [1:0]       np_col, zp_col;
  logic             np_done, zp_done, np_fd, zp_fd;

  int n_checks = 0;
  int n_fail   = 0;
  int np_pulses;
  int zp_pulses;

  ci_row_window_buffer #(
    .DATA_W(DW), .COLS(NC), .ROWS(NR), .TAPS(NT), .ZERO_PAD(0)
  ) dut_np (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i), .clear_i(clear_i),
    .taps_o(np_taps), .row_o(np_row), .col_o(np_col),
    .done_o(np_done), .frame_done_o(np_fd)
  );

  ci_row_window_buffer #(
    .DATA_W(DW), .COLS(NC), .ROWS(NR), .TAPS(NT), .ZERO_PAD(1)
  ) dut_zp (
    .clk(clk), .rst(rst), .done_i(done_i), .data_i(data_i), .clear_i(clear_i),
    .taps_o(zp_taps), .row_o(zp_row), .col_o(zp_col),
    .done_o(zp_done), .frame_done_o(zp_fd)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(16 * r + c);
  endfunction

  // Expected window for live pixel (r,c); rows before 0 read as zero
  function automatic logic [NT*DW-1:0] exp_taps(input int r, input int c);
    logic [NT*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NT; k++) begin
      if (r - (NT - 1 - k) >= 0) begin
        v[k*DW +: DW] = pix(r - (NT - 1 - k), c);
      end
    end
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel per call; outputs are sampled 1 time unit after the edge
  task automatic apply_stimulus(input logic [DW-1:0] v);
    @(negedge clk);
    done_i  = 1'b1;
    clear_i = 1'b0;
    data_i  = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      done_i = 1'b0;
      @(posedge clk);
      #1;
      check_output({tag, "/idle_np_done"}, 32'(np_done), 32'd0);
      check_output({tag, "/idle_zp_done"}, 32'(zp_done), 32'd0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "/np_done"}, 32'(np_done), 32'd0);
    check_output({tag, "/np_fd"},   32'(np_fd),   32'd0);
    check_output({tag, "/np_taps"}, 32'(np_taps), 32'd0);
    check_output({tag, "/np_row"},  32'(np_row),  32'd0);
    check_output({tag, "/np_col"},  32'(np_col),  32'd0);
    check_output({tag, "/zp_done"}, 32'(zp_done), 32'd0);
    check_output({tag, "/zp_fd"},   32'(zp_fd),   32'd0);
    check_output({tag, "/zp_taps"}, 32'(zp_taps), 32'd0);
    check_output({tag, "/zp_row"},  32'(zp_row),  32'd0);
    check_output({tag, "/zp_col"},  32'(zp_col),  32'd0);
  endtask

  task automatic check_pixel(input string tag, input int r, input int c);
    string t;
    logic  emit;
    logic  fd;
    t    = $sformatf("%s(%0d,%0d)", tag, r, c);
    emit = (r >= NT - 1);
    fd   = (r == NR - 1) && (c == NC - 1);
    np_pulses += int'(np_done);
    zp_pulses += int'(zp_done);
    check_output({t, "/np_done"}, 32'(np_done), 32'(emit));
    check_output({t, "/np_fd"},   32'(np_fd),   32'(fd));
    if (emit) begin
      check_output({t, "/np_taps"}, 32'(np_taps), 32'(exp_taps(r, c)));
      check_output({t, "/np_row"},  32'(np_row),  32'(r));
      check_output({t, "/np_col"},  32'(np_col),  32'(c));
    end
    check_output({t, "/zp_done"}, 32'(zp_done), 32'd1);
    check_output({t, "/zp_fd"},   32'(zp_fd),   32'(fd));
    check_output({t, "/zp_taps"}, 32'(zp_taps), 32'(exp_taps(r, c)));
    check_output({t, "/zp_row"},  32'(zp_row),  32'(r));
    check_output({t, "/zp_col"},  32'(zp_col),  32'(c));
    // Hand-computed anchor points
    if (r == 2 && c == 0) check_output({t, "/np_first_taps"}, 32'(np_taps), 32'h201000);
    if (r == 5 && c == 3) check_output({t, "/np_last_taps"},  32'(np_taps), 32'h534333);
    if (r == 1 && c == 2) check_output({t, "/zp_pad_taps"},   32'(zp_taps), 32'h120200);
    if (r == 0 && c == 0) check_output({t, "/zp_origin_taps"}, 32'(zp_taps), 32'h000000);
  endtask

  task automatic run_frame(input string tag, input int max_gap);
    np_pulses = 0;
    zp_pulses = 0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        apply_stimulus(pix(r, c));
        check_pixel(tag, r, c);
        if (max_gap > 0) begin
          idle_cycles(tag, int'($urandom_range(0, max_gap)));
        end
      end
    end
    check_output({tag, "/np_pulse_count"}, 32'(np_pulses), 32'((NR - NT + 1) * NC));
    check_output({tag, "/zp_pulse_count"}, 32'(zp_pulses), 32'(NR * NC));
  endtask

  initial begin
    // Reset held with the strobe toggling; nothing may leak out
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      done_i = ~done_i;
      data_i = 8'hA5;
      @(posedge clk);
      #1;
      check_all_zero($sformatf("reset%0d", i));
    end
    @(negedge clk);
    done_i = 1'b0;
    rst    = 1'b0;
    $display("[TB] reset released");

    // Two frames back to back, then an idle check
    run_frame("frame1", 0);
    run_frame("frame2", 0);
    idle_cycles("post2", 2);

    // Partial frame aborted by clear at (3,1); that pixel is dropped
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < NC; c++) begin
        if (r < 3 || c == 0) begin
          apply_stimulus(pix(r, c));
          check_pixel("pre_clear", r, c);
        end
      end
    end
    @(negedge clk);
    done_i  = 1'b1;
    clear_i = 1'b1;
    data_i  = pix(3, 1);
    @(posedge clk);
    #1;
    check_output("clear/np_done", 32'(np_done), 32'd0);
    check_output("clear/zp_done", 32'(zp_done), 32'd0);
    check_output("clear/np_fd",   32'(np_fd),   32'd0);
    check_output("clear/zp_fd",   32'(zp_fd),   32'd0);
    // Window refills from empty: 8 silent pixels on np, the 9th is (2,0)
    run_frame("after_clear", 0);

    // Random idle gaps must not change the emitted sequence
    run_frame("gappy", 3);

    // Asynchronous reset in the middle of a frame
    for (int c = 0; c < 2; c++) begin
      apply_stimulus(pix(0, c));
      check_pixel("pre_rst", 0, c);
    end
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    done_i = 1'b0;
    rst    = 1'b0;
    run_frame("after_rst", 0);
    idle_cycles("tail", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
